// File: rtl/execute_if.sv
// Decode-to-execute handshake bundle: decode outputs and hazard/status controls in,
// E-register taps and the e_* bundle for the memory-stage register out.
interface execute_if #(
    parameter int WORD = 64
);
    logic            E_bubble;
    logic [3:0]      d_stat;
    logic [3:0]      d_icode;
    logic [3:0]      d_ifun;
    logic [WORD-1:0] d_valC;
    logic [WORD-1:0] d_valA;
    logic [WORD-1:0] d_valB;
    logic [3:0]      d_dstE;
    logic [3:0]      d_dstM;
    logic [3:0]      d_srcA;
    logic [3:0]      d_srcB;
    logic [3:0]      m_stat;
    logic [3:0]      W_stat;

    logic [3:0]      E_icode;
    logic [3:0]      E_dstM;
    logic [3:0]      E_srcA;
    logic [3:0]      E_srcB;
    logic [3:0]      e_stat;
    logic [3:0]      e_icode;
    logic            e_Cnd;
    logic [WORD-1:0] e_valE;
    logic [WORD-1:0] e_valA;
    logic [3:0]      e_dstE;
    logic [3:0]      e_dstM;
    logic [2:0]      cc;

    modport master (
        output E_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat,
        input  E_icode, E_dstM, E_srcA, E_srcB, e_stat, e_icode, e_Cnd,
               e_valE, e_valA, e_dstE, e_dstM, cc
    );

    modport slave (
        input  E_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat,
        output E_icode, E_dstM, E_srcA, E_srcB, e_stat, e_icode, e_Cnd,
               e_valE, e_valA, e_dstE, e_dstM, cc
    );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU, condition-code register and
// jXX/cmovXX condition evaluation feeding the memory-stage register.
module execute_stage #(
    parameter int         WORD  = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    execute_if.slave   bus
);
    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] S_HLT    = 4'h2;
    localparam logic [3:0] S_ADR    = 4'h3;
    localparam logic [3:0] S_INS    = 4'h4;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;

    typedef struct packed {
        logic [3:0]      stat;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [WORD-1:0] valC;
        logic [WORD-1:0] valA;
        logic [WORD-1:0] valB;
        logic [3:0]      dstE;
        logic [3:0]      dstM;
        logic [3:0]      srcA;
        logic [3:0]      srcB;
    } ereg_t;

    localparam ereg_t BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        valC:  '0,
        valA:  '0,
        valB:  '0,
        dstE:  RNONE,
        dstM:  RNONE,
        srcA:  RNONE,
        srcB:  RNONE
    };

    ereg_t           e_q;
    ereg_t           d_in;
    logic [2:0]      cc_q;

    logic [WORD-1:0] alu_a;
    logic [WORD-1:0] alu_b;
    logic [3:0]      alu_fun;
    logic [WORD-1:0] val_e;
    logic            zf;
    logic            sf;
    logic            of;
    logic            set_cc;
    logic            cnd;

    assign d_in = '{
        stat:  bus.d_stat,
        icode: bus.d_icode,
        ifun:  bus.d_ifun,
        valC:  bus.d_valC,
        valA:  bus.d_valA,
        valB:  bus.d_valB,
        dstE:  bus.d_dstE,
        dstM:  bus.d_dstM,
        srcA:  bus.d_srcA,
        srcB:  bus.d_srcB
    };

    // Only OPq writes CC, and only while no older instruction has faulted or halted.
    assign set_cc = (e_q.icode == I_OPQ)
                 && !(bus.m_stat inside {S_HLT, S_ADR, S_INS})
                 && !(bus.W_stat inside {S_HLT, S_ADR, S_INS});

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            e_q  <= BUBBLE;
            cc_q <= 3'b100;
        end else begin
            e_q <= bus.E_bubble ? BUBBLE : d_in;
            if (set_cc) begin
                cc_q <= {zf, sf, of};
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        alu_a = '0;
        case (e_q.icode)
            I_RRMOVQ, I_OPQ:             alu_a = e_q.valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_q.valC;
            I_CALL, I_PUSHQ:             alu_a = ~WORD'(7);
            I_RET, I_POPQ:               alu_a = WORD'(8);
            default:                     alu_a = '0;
        endcase

        alu_b = '0;
        case (e_q.icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = e_q.valB;
            default:                        alu_b = '0;
        endcase
    end

    assign alu_fun = (e_q.icode == I_OPQ) ? e_q.ifun : ALU_ADD;

    always_comb begin
        val_e = '0;
        of    = 1'b0;
        case (alu_fun)
            ALU_ADD: begin
                val_e = alu_b + alu_a;
                of    = (alu_a[WORD-1] == alu_b[WORD-1]) && (val_e[WORD-1] != alu_a[WORD-1]);
            end
            ALU_SUB: begin
                val_e = alu_b - alu_a;
                of    = (alu_a[WORD-1] != alu_b[WORD-1]) && (val_e[WORD-1] != alu_b[WORD-1]);
            end
            ALU_AND: val_e = alu_b & alu_a;
            ALU_XOR: val_e = alu_b ^ alu_a;
            default: val_e = '0;
        endcase
    end

    assign zf = (val_e == '0);
    assign sf = val_e[WORD-1];

    // Condition uses the stored flags, never the ones being written this cycle.
    always_comb begin
        cnd = 1'b0;
        case (e_q.ifun)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'h2:    cnd = cc_q[1] ^ cc_q[0];
            4'h3:    cnd = cc_q[2];
            4'h4:    cnd = ~cc_q[2];
            4'h5:    cnd = ~(cc_q[1] ^ cc_q[0]);
            4'h6:    cnd = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
            default: cnd = 1'b0;
        endcase
    end

    assign bus.E_icode = e_q.icode;
    assign bus.E_dstM  = e_q.dstM;
    assign bus.E_srcA  = e_q.srcA;
    assign bus.E_srcB  = e_q.srcB;
    assign bus.e_stat  = e_q.stat;
    assign bus.e_icode = e_q.icode;
    assign bus.e_Cnd   = cnd;
    assign bus.e_valE  = val_e;
    assign bus.e_valA  = e_q.valA;
    assign bus.e_dstE  = (e_q.icode == I_RRMOVQ && !cnd) ? RNONE : e_q.dstE;
    assign bus.e_dstM  = e_q.dstM;
    assign bus.cc      = cc_q;
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboarded bench for execute_stage: directed pipeline scenarios followed by
// random traffic, all checked against a behavioural model of the stage.
module tb_execute_stage;
    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } instr_t;

    typedef struct packed {
        logic [3:0]  E_icode;
        logic [3:0]  E_dstM;
        logic [3:0]  E_srcA;
        logic [3:0]  E_srcB;
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [2:0]  cc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    execute_if bus ();
    execute_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t   sb[$];
    int     n_vec = 0;
    int     n_bad = 0;
    instr_t m_e;
    logic [2:0] m_cc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                                  input logic [63:0] valC, input logic [63:0] valA,
                                  input logic [63:0] valB, input logic [3:0] dstE);
        instr_t i;
        i.stat = 4'h1; i.icode = icode; i.ifun = ifun;
        i.valC = valC; i.valA = valA; i.valB = valB;
        i.dstE = dstE; i.dstM = RNONE; i.srcA = RNONE; i.srcB = RNONE;
        return i;
    endfunction

    function automatic instr_t nop_i();
        return mk(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, RNONE);
    endfunction

    // Reference ALU: operands chosen by instruction class; overflow judged by
    // doing the arithmetic one bit wider in two's complement.
    function automatic logic [63:0] alu(input instr_t i, output logic [2:0] f);
        logic [63:0] a, b, v;
        logic signed [64:0] wide;
        logic [3:0] op;
        logic ofl;
        a = 64'h0; b = 64'h0; ofl = 1'b0; v = 64'h0;
        if (i.icode inside {4'd2, 4'd6})             a = i.valA;
        else if (i.icode inside {[4'd3:4'd5]})       a = i.valC;
        else if (i.icode inside {4'd8, 4'd10})       a = -64'd8;
        else if (i.icode inside {4'd9, 4'd11})       a = 64'd8;
        if (i.icode inside {[4'd4:4'd6], [4'd8:4'd11]}) b = i.valB;
        op = (i.icode == 4'd6) ? i.ifun : 4'd0;
        case (op)
            4'd0: begin
                v = b + a;
                wide = $signed({b[63], b}) + $signed({a[63], a});
                ofl = (wide[64] != wide[63]);
            end
            4'd1: begin
                v = b - a;
                wide = $signed({b[63], b}) - $signed({a[63], a});
                ofl = (wide[64] != wide[63]);
            end
            4'd2: v = b & a;
            4'd3: v = b ^ a;
            default: v = 64'h0;
        endcase
        f = {(v == 64'h0), v[63], ofl};
        return v;
    endfunction

    function automatic logic cond(input logic [3:0] ifun, input logic [2:0] c);
        logic zf, less;
        zf = c[2];
        less = (c[1] != c[0]);
        case (ifun)
            4'd0: return 1'b1;
            4'd1: return less || zf;
            4'd2: return less;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !less;
            4'd6: return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model, queue the expectation.
    task automatic step(input instr_t d, input logic bub, input logic rv,
                        input logic [3:0] ms, input logic [3:0] ws);
        logic [2:0] f;
        logic [63:0] v;
        exp_t x;
        bus.E_bubble = bub;
        bus.d_stat = d.stat; bus.d_icode = d.icode; bus.d_ifun = d.ifun;
        bus.d_valC = d.valC; bus.d_valA = d.valA; bus.d_valB = d.valB;
        bus.d_dstE = d.dstE; bus.d_dstM = d.dstM; bus.d_srcA = d.srcA; bus.d_srcB = d.srcB;
        bus.m_stat = ms; bus.W_stat = ws;
        rst_n = rv;
        @(posedge clk);
        #1;
        if (!rv) begin
            m_e = nop_i();
            m_cc = 3'b100;
        end else begin
            v = alu(m_e, f);
            if (m_e.icode == 4'd6 && !(ms inside {[4'd2:4'd4]}) && !(ws inside {[4'd2:4'd4]}))
                m_cc = f;
            m_e = bub ? nop_i() : d;
        end
        x.valE = alu(m_e, f);
        x.cnd = cond(m_e.ifun, m_cc);
        x.dstE = (m_e.icode == 4'd2 && !x.cnd) ? RNONE : m_e.dstE;
        x.E_icode = m_e.icode; x.E_dstM = m_e.dstM; x.E_srcA = m_e.srcA; x.E_srcB = m_e.srcB;
        x.stat = m_e.stat; x.icode = m_e.icode; x.valA = m_e.valA; x.dstM = m_e.dstM;
        x.cc = m_cc;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            check("E_icode", 64'(bus.E_icode), 64'(x.E_icode));
            check("E_dstM",  64'(bus.E_dstM),  64'(x.E_dstM));
            check("E_srcA",  64'(bus.E_srcA),  64'(x.E_srcA));
            check("E_srcB",  64'(bus.E_srcB),  64'(x.E_srcB));
            check("e_stat",  64'(bus.e_stat),  64'(x.stat));
            check("e_icode", 64'(bus.e_icode), 64'(x.icode));
            check("e_Cnd",   64'(bus.e_Cnd),   64'(x.cnd));
            check("e_valE",  bus.e_valE,       x.valE);
            check("e_valA",  bus.e_valA,       x.valA);
            check("e_dstE",  64'(bus.e_dstE),  64'(x.dstE));
            check("e_dstM",  64'(bus.e_dstM),  64'(x.dstM));
            check("cc",      64'(bus.cc),      64'(x.cc));
        end
    end

    function automatic logic [63:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 64'h0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 16));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    function automatic logic [3:0] rand_stat();
        return ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 7)) : 4'h1;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        instr_t r;
        step(nop_i(), 1'b0, 1'b0, 4'h1, 4'h1);
        step(nop_i(), 1'b0, 1'b0, 4'h1, 4'h1);
        @(negedge clk);
        check("rst E_icode", 64'(bus.E_icode), 64'h1);
        check("rst e_dstE",  64'(bus.e_dstE),  64'hF);
        check("rst e_dstM",  64'(bus.e_dstM),  64'hF);
        check("rst e_valE",  bus.e_valE,       64'h0);
        check("rst cc",      64'(bus.cc),      64'h4);
        check("rst e_stat",  64'(bus.e_stat),  64'h1);

        step(mk(4'h6, 4'h1, 64'h0, 64'd5, 64'd3, 4'h2), 1'b0, 1'b1, 4'h1, 4'h1);
        @(negedge clk);
        check("sub e_valE", bus.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub e_dstE", 64'(bus.e_dstE), 64'h2);
        step(nop_i(), 1'b0, 1'b1, 4'h1, 4'h1);
        @(negedge clk);
        check("sub cc", 64'(bus.cc), 64'h2);

        step(mk(4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h3),
             1'b0, 1'b1, 4'h1, 4'h1);
        @(negedge clk);
        check("ovf e_valE", bus.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        step(nop_i(), 1'b0, 1'b1, 4'h1, 4'h1);
        @(negedge clk);
        check("ovf cc", 64'(bus.cc), 64'h3);
        step(mk(4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'h1), 1'b0, 1'b1, 4'h1, 4'h1);
        step(nop_i(), 1'b0, 1'b1, 4'h3, 4'h1);
        @(negedge clk);
        check("gated cc", 64'(bus.cc), 64'h3);

        step(mk(4'h6, 4'h3, 64'h0, 64'd5, 64'd5, 4'h1), 1'b0, 1'b1, 4'h1, 4'h1);
        step(mk(4'h2, 4'h4, 64'h0, 64'h55, 64'h0, 4'h5), 1'b0, 1'b1, 4'h1, 4'h1);
        @(negedge clk);
        check("cmovne cc",    64'(bus.cc),     64'h4);
        check("cmovne e_Cnd", 64'(bus.e_Cnd),  64'h0);
        check("cmovne e_dstE", 64'(bus.e_dstE), 64'hF);
        step(mk(4'h2, 4'h3, 64'h0, 64'h55, 64'h0, 4'h5), 1'b0, 1'b1, 4'h1, 4'h1);
        @(negedge clk);
        check("cmove e_Cnd",  64'(bus.e_Cnd),  64'h1);
        check("cmove e_dstE", 64'(bus.e_dstE), 64'h5);
        check("cmove e_valE", bus.e_valE,      64'h55);

        step(mk(4'hA, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4), 1'b0, 1'b1, 4'h1, 4'h1);
        @(negedge clk);
        check("pushq e_valE", bus.e_valE, 64'hF8);
        step(mk(4'hB, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4), 1'b0, 1'b1, 4'h1, 4'h1);
        @(negedge clk);
        check("popq e_valE", bus.e_valE, 64'h108);
        step(mk(4'h8, 4'h0, 64'h0, 64'h1234, 64'h100, 4'h4), 1'b0, 1'b1, 4'h1, 4'h1);
        @(negedge clk);
        check("call e_valE", bus.e_valE, 64'hF8);
        check("call e_valA", bus.e_valA, 64'h1234);

        step(mk(4'h6, 4'h1, 64'h0, 64'd5, 64'd3, 4'h2), 1'b1, 1'b1, 4'h1, 4'h1);
        @(negedge clk);
        check("bubble E_icode", 64'(bus.E_icode), 64'h1);
        check("bubble e_dstE",  64'(bus.e_dstE),  64'hF);
        step(nop_i(), 1'b0, 1'b1, 4'h1, 4'h1);
        @(negedge clk);
        check("bubble cc", 64'(bus.cc), 64'h4);

        step(mk(4'h6, 4'h1, 64'h0, 64'd5, 64'd3, 4'h2), 1'b0, 1'b1, 4'h1, 4'h1);
        step(mk(4'h6, 4'h0, 64'h0, 64'd1, 64'd1, 4'h3), 1'b0, 1'b1, 4'h1, 4'h1);
        step(nop_i(), 1'b0, 1'b0, 4'h1, 4'h1);
        @(negedge clk);
        check("rst-opq cc",      64'(bus.cc),      64'h4);
        check("rst-opq E_icode", 64'(bus.E_icode), 64'h1);

        for (int n = 0; n < 400; n++) begin
            r.stat  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
            r.icode = 4'($urandom_range(0, 11));
            r.ifun  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 6));
            r.valC  = rand_word();
            r.valA  = rand_word();
            r.valB  = rand_word();
            r.dstE  = 4'($urandom());
            r.dstM  = 4'($urandom());
            r.srcA  = 4'($urandom());
            r.srcB  = 4'($urandom());
            step(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) != 0),
                 rand_stat(), rand_stat());
        end

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        @(posedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipeline execute stage, directly downstream of the decode stage.
- Contains the E pipeline register, which latches decode outputs each cycle, plus the ALU, the condition-code register and the branch/cmov condition evaluation.
- Produces e_valE/e_dstE for decode forwarding and the full e_* bundle latched by the memory-stage register.

Parameters:
- WORD, 64, datapath width of valC/valA/valB/valE.
- RNONE, 4'hF, register ID meaning "no register".

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- E_bubble  in  1  insert nop into E register at this edge (from hazard control).
- d_stat  in  4  decode status.
- d_icode  in  4  decode instruction code.
- d_ifun  in  4  decode function code.
- d_valC  in  64  decode constant.
- d_valA  in  64  decode forwarded operand A.
- d_valB  in  64  decode forwarded operand B.
- d_dstE  in  4  decode E destination.
- d_dstM  in  4  decode M destination.
- d_srcA  in  4  decode source A.
- d_srcB  in  4  decode source B.
- m_stat  in  4  memory-stage status (CC gating).
- W_stat  in  4  writeback status (CC gating).
- E_icode  out  4  registered icode (hazard unit).
- E_dstM  out  4  registered dstM (load-use detect).
- E_srcA  out  4  registered srcA.
- E_srcB  out  4  registered srcB.
- e_stat  out  4  status to M register.
- e_icode  out  4  icode to M register.
- e_Cnd  out  1  condition result (jXX/cmovXX).
- e_valE  out  64  ALU result.
- e_valA  out  64  pass-through valA.
- e_dstE  out  4  effective E destination.
- e_dstM  out  4  pass-through dstM.
- cc  out  3  {ZF,SF,OF}.

Behaviour:
- Reset (rst_n=0 at edge): E register loads the bubble state: stat=1 (AOK), icode=1 (nop), ifun=0, valC/valA/valB=0, dstE/dstM/srcA/srcB=RNONE. cc<=3'b100 (ZF=1).
- Reset has priority over E_bubble.
- Normal edge: E register loads all d_* fields. E_bubble=1 loads the bubble state instead. There is no stall input; E always advances.
- e_* outputs are combinational from the E register; they settle in the same cycle after the edge, i.e. one-cycle latency from d_* to e_*.
- aluA:
  - valA for icode 2, 6.
  - valC for icode 3, 4, 5.
  - -8 for icode 8, 10.
  - +8 for icode 9, 11.
  - 0 otherwise.
- aluB:
  - valB for icode 4, 5, 6, 8, 9, 10, 11.
  - 0 for icode 2, 3 and otherwise.
- ALU function is E_ifun when icode=6, else add. Functions: 0 add (B+A), 1 sub (B−A), 2 and, 3 xor.
- Arithmetic wraps mod 2^64. OpQ with ifun>3 produces valE=0 and flags from 0.
- Flags: ZF=(valE==0); SF=valE[63].
- OF for add: A[63]==B[63] && valE[63]!=A[63].
- OF for sub: A[63]!=B[63] && valE[63]!=B[63].
- OF=0 for and/xor.
- set_cc = (E_icode==6) && m_stat∉{2,3,4} && W_stat∉{2,3,4}. When set_cc is true, cc updates at the next rising edge; otherwise it holds.
- The CC write and an E_bubble at the same edge are independent: the CC update still happens for the instruction currently in E.
- e_Cnd is evaluated from the current cc register, not the value being written:
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): ~ZF.
  - ifun 5 (ge): ~(SF^OF).
  - ifun 6 (g): ~(SF^OF)&~ZF.
  - ifun >6: 0.
- e_Cnd is meaningful for icode 2 and 7; for other icodes it is driven but ignored downstream.
- e_dstE = RNONE when E_icode==2 && !e_Cnd, else E_dstE.
- e_stat = E_stat, e_icode = E_icode, e_valA = E_valA, e_dstM = E_dstM, all unchanged.
- Non-AOK E_stat does not block the ALU; only the CC write is blocked, via the m_stat/W_stat rule and by requiring icode 6.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks → E_icode=1, e_dstE=e_dstM=4'hF, e_valE=0, cc=3'b100, e_stat=1.
- OpQ sub: d_icode=6, ifun=1, valA=5, valB=3, dstE=2 → next cycle e_valE=0xFFFF_FFFF_FFFF_FFFE, e_dstE=2; following edge cc=3'b010.
- Overflow: add valA=valB=0x7FFF_FFFF_FFFF_FFFF → e_valE=0xFFFF_FFFF_FFFF_FFFE, cc becomes 3'b011. With m_stat=3 held during that cycle → cc unchanged.
- Conditional move: cc=3'b100, cmovne (icode 2, ifun 4, dstE=5, valA=0x55) → e_Cnd=0, e_dstE=4'hF. Repeat with cmove (ifun 3) → e_Cnd=1, e_dstE=5, e_valE=0x55.
- Stack ops: pushq valB=0x100 → e_valE=0xF8. popq valB=0x100 → e_valE=0x108. call valB=0x100 → e_valE=0xF8, e_valA=d_valA passthrough.
- Bubble: E_bubble=1 with d_icode=6 presented → E_icode=1, e_dstE=4'hF, cc not updated on the following edge. Asserting rst_n=0 together with an opq in E → bubble state, cc=3'b100.
